// File: rtl/m8_to_4_if.sv
// Sensor-to-actuator bus for the CHS controller.
//   in         : 8-bit unsigned temperature code (sensor side drives)
//   chs_power  : 5-bit actuator power level (controller drives)
//   chs_mode   : 1 = cooling, 0 = heating/idle (controller drives)
// master = sensor/driver side, slave = m8_to_4 controller.
interface m8_to_4_if;
  logic [7:0] in;
  logic [4:0] chs_power;
  logic       chs_mode;

  modport master (output in, input chs_power, input chs_mode);
  modport slave  (input in, output chs_power, output chs_mode);
endinterface

// File: rtl/m8_to_4.sv
// CHS controller: maps an 8-bit temperature code to a 5-bit actuator power level
// and a heat/cool mode flag using a 3-state hysteresis FSM (IDLE/HEAT/COOL).
// Ports:
//   clk : clock, all updates on rising edge
//   rst : asynchronous active-high reset
//   bus : m8_to_4_if.slave (in, chs_power, chs_mode); outputs are registered
// Optional build macro CHS_RAMP_EN: slew-limits chs_power to +/-1 per cycle and
// restarts the ramp from 0 on every mode change.
module m8_to_4 #(
  parameter int unsigned T_LOW  = 15,
  parameter int unsigned T_HIGH = 35,
  parameter int unsigned HYST   = 2,
  parameter int unsigned PMAX   = 31
) (
  input  logic       clk,
  input  logic       rst,
  m8_to_4_if.slave   bus
);

  localparam int unsigned PWR_W  = 5;
  localparam int unsigned CALC_W = 10;

  localparam logic [CALC_W-1:0] T_LOW_C   = CALC_W'(T_LOW);
  localparam logic [CALC_W-1:0] T_HIGH_C  = CALC_W'(T_HIGH);
  localparam logic [CALC_W-1:0] HEAT_OFF  = CALC_W'(T_LOW + HYST);
  localparam logic [CALC_W-1:0] COOL_OFF  = CALC_W'(T_HIGH - HYST);
  localparam logic [CALC_W-1:0] PMAX_C    = CALC_W'(PMAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CALC_W-1:0]  in_w;
  logic [CALC_W-1:0]  diff;
  logic [PWR_W-1:0]   target;
  logic [PWR_W-1:0]   power_q, power_d;
  logic               mode_q, mode_d;
`ifdef CHS_RAMP_EN
  logic [PWR_W-1:0]   ramp_base;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      power_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      power_q <= power_d;
      mode_q  <= mode_d;
    end
  end

  // Next state, target power and next output values
  always_comb begin
    state_d = state_q;
    diff    = '0;
    target  = '0;
    in_w    = CALC_W'(bus.in);

    unique case (state_q)
      IDLE: begin
        if (in_w < T_LOW_C)       state_d = HEAT;
        else if (in_w > T_HIGH_C) state_d = COOL;
      end
      HEAT: begin
        if (in_w > T_HIGH_C)       state_d = COOL;
        else if (in_w >= HEAT_OFF) state_d = IDLE;
      end
      COOL: begin
        if (in_w < T_LOW_C)        state_d = HEAT;
        else if (in_w <= COOL_OFF) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Distance past the hysteresis edge; the next-state rules guarantee it is >= 1
    case (state_d)
      HEAT:    diff = HEAT_OFF - in_w;
      COOL:    diff = in_w - COOL_OFF;
      default: diff = '0;
    endcase
    target = (diff > PMAX_C) ? PWR_W'(PMAX) : diff[PWR_W-1:0];

    mode_d = (state_d == COOL);

`ifdef CHS_RAMP_EN
    // A mode flip restarts the ramp from 0, so the first step lands on 1
    ramp_base = (mode_d != mode_q) ? '0 : power_q;
    if (target > ramp_base)      power_d = ramp_base + PWR_W'(1);
    else if (target < ramp_base) power_d = ramp_base - PWR_W'(1);
    else                         power_d = ramp_base;
`else
    power_d = target;
`endif
  end

  assign bus.chs_power = power_q;
  assign bus.chs_mode  = mode_q;

endmodule

// File: tb/tb_m8_to_4.sv
// Bench for m8_to_4: directed steps followed by random temperature codes, all
// checked against an arithmetic reference model of the controller.
module tb_m8_to_4;

  localparam int T_LOW  = 15;
  localparam int T_HIGH = 35;
  localparam int HYST   = 2;
  localparam int PMAX   = 31;

  localparam int S_IDLE = 0;
  localparam int S_HEAT = 1;
  localparam int S_COOL = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  m8_to_4_if bus ();

  m8_to_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int m_state;
  int m_power;
  int m_mode;

  function automatic void model_reset();
    m_state = S_IDLE;
    m_power = 0;
    m_mode  = 0;
  endfunction

  function automatic void model_step(input int t);
    int ns;
    int tgt;
    int base;
    ns = m_state;
    if (m_state == S_IDLE) begin
      if (t < T_LOW) ns = S_HEAT;
      else if (t > T_HIGH) ns = S_COOL;
    end else if (m_state == S_HEAT) begin
      if (t > T_HIGH) ns = S_COOL;
      else if (t >= T_LOW + HYST) ns = S_IDLE;
    end else begin
      if (t < T_LOW) ns = S_HEAT;
      else if (t <= T_HIGH - HYST) ns = S_IDLE;
    end
    tgt = 0;
    if (ns == S_HEAT) tgt = (T_LOW + HYST) - t;
    if (ns == S_COOL) tgt = t - (T_HIGH - HYST);
    if (tgt > PMAX) tgt = PMAX;
`ifdef CHS_RAMP_EN
    base = (((ns == S_COOL) ? 1 : 0) != m_mode) ? 0 : m_power;
    if (tgt > base)      m_power = base + 1;
    else if (tgt < base) m_power = base - 1;
    else                 m_power = base;
`else
    base    = 0;
    m_power = tgt + base;
`endif
    m_mode  = (ns == S_COOL) ? 1 : 0;
    m_state = ns;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive at negedge, compare #1 after the following rising edge
  task automatic apply(input logic [7:0] v, input string tag);
    @(negedge clk);
    bus.in = v;
    model_step(int'(v));
    @(posedge clk);
    #1;
    check({tag, ".power"}, 8'(bus.chs_power), 8'(m_power));
    check({tag, ".mode"},  8'(bus.chs_mode),  8'(m_mode));
  endtask

  // Same as apply, plus a check against the literal value for the default build
  task automatic apply_lit(input logic [7:0] v, input string tag,
                           input logic [7:0] exp_p, input logic [7:0] exp_m);
    apply(v, tag);
`ifndef CHS_RAMP_EN
    check({tag, ".lit_power"}, 8'(bus.chs_power), exp_p);
    check({tag, ".lit_mode"},  8'(bus.chs_mode),  exp_m);
`endif
  endtask

  initial begin
    logic [7:0] v;
    rst    = 1'b1;
    bus.in = 8'h00;
    model_reset();
    #12;
    check("reset.power", 8'(bus.chs_power), 8'd0);
    check("reset.mode",  8'(bus.chs_mode),  8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle band and lower boundary
    apply_lit(8'h19, "idle25",   8'd0,  8'd0);
    apply_lit(8'h0F, "idle15",   8'd0,  8'd0);
    // Heating and hysteresis release
    apply_lit(8'h0A, "heat10",   8'd7,  8'd0);
    apply_lit(8'd16, "heat16",   8'd1,  8'd0);
    apply_lit(8'd17, "heatoff",  8'd0,  8'd0);
    // Upper boundary does not enter COOL
    apply_lit(8'd35, "idle35",   8'd0,  8'd0);
    // Cooling, saturation and release
    apply_lit(8'hFF, "cool255",  8'd31, 8'd1);
    apply_lit(8'd36, "cool36",   8'd3,  8'd1);
    apply_lit(8'd33, "cooloff",  8'd0,  8'd0);
    // Direct COOL -> HEAT jump
    apply_lit(8'hFF, "cool2",    8'd31, 8'd1);
    apply_lit(8'h00, "jump",     8'd17, 8'd0);
    // Direct HEAT -> COOL jump
    apply_lit(8'hFF, "jump2",    8'd31, 8'd1);

    // Asynchronous reset mid-run with in held at 255
    for (int i = 0; i < 35; i++) apply(8'hFF, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.power", 8'(bus.chs_power), 8'd0);
    check("async_rst.mode",  8'(bus.chs_mode),  8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(8'd25, "post_rst");

    // Random codes, biased toward the interesting band around the thresholds
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      else                           v = 8'($urandom_range(0, 52));
      apply(v, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
